test_sequencer: RTL and testbench
=================================

Name: test_sequencer

Overview:
- Sequences the board self-tests (SD, SDRAM, mouse, memory, ...) one at a time on the shared 7 MHz test clock.
- For each selected test:
  - pulses that test's init/reset line;
  - waits for its progress flag to rise, then fall;
  - latches its result.
- Bounded timeouts guard every wait.
- Sits between the key-decoder/start source and the test engines. Summary masks feed the message updater and the board LEDs.

Parameters:
- NUM_TESTS, 4, number of test engines sequenced (index 0 runs first).
- INIT_CYCLES, 16, length in clk cycles of each init pulse (>=1).
- START_TIMEOUT, 1024, cycles allowed after the init pulse for progress to go high.
- RUN_TIMEOUT, 2**22, cycles allowed with progress high before declaring a hang.
- TMR_W, 24, timer width; must hold max(START_TIMEOUT, RUN_TIMEOUT).

Ports:
- clk  in  1  test clock (clk7 domain); all inputs synchronous to it.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle request to run a sequence.
- run_mask  in  NUM_TESTS  tests to execute; sampled on accepted start.
- test_progress  in  NUM_TESTS  per-engine "test running" flag.
- test_result  in  NUM_TESTS  per-engine result (1 = pass); valid when progress is low.
- test_init  out  NUM_TESTS  per-engine init pulse, one-hot or zero.
- busy  out  1  sequence in progress.
- done  out  1  one-cycle pulse at sequence end.
- cur_test  out  clog2(NUM_TESTS)  index of the test being run.
- pass_mask  out  NUM_TESTS  tests that completed with result 1.
- fail_mask  out  NUM_TESTS  tests that completed with result 0 or timed out.
- timeout_mask  out  NUM_TESTS  subset of fail_mask caused by timeout.
- led_ok  out  1  high when the last sequence finished with fail_mask == 0 and run_mask != 0.

Behaviour:
- Reset values: all outputs 0; state IDLE; timer 0.
- IDLE
  - start=1 → latch run_mask into the pending mask, clear all result masks, busy=1 next cycle, go to SELECT.
  - start while busy is ignored.
- SELECT
  - Picks the lowest set bit of the pending mask and sets cur_test to it; go to INIT.
  - Pending mask zero → go to FINISH.
- INIT
  - test_init[cur_test]=1 for exactly INIT_CYCLES cycles, starting the cycle after SELECT.
  - Timer is cleared on exit. Go to WAIT_START.
- WAIT_START
  - progress[cur]=1 → clear timer, go to WAIT_END.
  - Timer reaches START_TIMEOUT-1 → set fail_mask[cur] and timeout_mask[cur], go to NEXT.
  - Progress already high on the first WAIT_START cycle counts as started.
- WAIT_END
  - progress[cur]=0 → sample result[cur] on that same cycle: 1 sets pass_mask[cur], 0 sets fail_mask[cur]. Go to NEXT.
  - Timer reaches RUN_TIMEOUT-1 with progress still high → timeout as above.
- NEXT
  - Clears the pending bit for cur, go to SELECT.
  - Per-test overhead after progress falls: 2 cycles.
- FINISH
  - done=1 for one cycle, busy=0, led_ok updated; return to IDLE.
  - Masks hold until the next accepted start.
- Invariants
  - Only one test_init bit is ever high.
  - Engines not in run_mask never see init.
  - pass_mask & fail_mask == 0.
  - Timer saturates; it never wraps.
- Boundary cases
  - run_mask == 0 → SELECT→FINISH; done 2 cycles after start; led_ok=0.
  - start and progress changes on the same cycle in IDLE: progress is ignored.
  - rst mid-sequence: outputs drop to 0 asynchronously and test_init deasserts immediately.

Optional Feature:
- Macro: TEST_SEQUENCER_LOOP_EN.
- Defined:
  - FINISH asserts done, then relaunches automatically with the last latched run_mask after 2**16 idle cycles. busy stays high through the gap.
  - fail_mask and timeout_mask become sticky across loops; pass_mask is recomputed each loop.
  - start in the loop gap is ignored.
  - Loop stops only via rst.
- Undefined: single-shot behaviour as above; no loop logic synthesised.

Decomposition:
- Package test_sequencer_pkg: state encoding (IDLE, SELECT, INIT, WAIT_START, WAIT_END, NEXT, FINISH, LOOP_GAP) and the LOOP_GAP_CYCLES constant.
- Sub-module seq_timer: clear/enable saturating counter with a terminal-compare output. It is shared by the INIT, WAIT_START, WAIT_END and loop-gap phases.

Test Plan:
- run_mask=4'b0101, engines respond (progress high 3 cycles after init falls, low 100 cycles later, result=1) → init[0] 16 cycles, then init[2] only; pass_mask=0101; fail_mask=0; done pulse; led_ok=1.
- run_mask=4'b0010, engine 1 never raises progress → timeout after 1024 cycles; fail_mask=timeout_mask=0010; led_ok=0.
- run_mask=4'b1000, progress stuck high (RUN_TIMEOUT overridden to 64) → timeout_mask=1000 at cycle 64 after start of WAIT_END.
- run_mask=0 → done 2 cycles after start; all masks 0; no init bit ever asserts.
- Second start pulse during WAIT_END → ignored; rst asserted in INIT → test_init and busy drop to 0 immediately; next start runs cleanly.
- TEST_SEQUENCER_LOOP_EN defined, engine 0 fails once then passes → fail_mask[0] stays 1 across loops; relaunch 65536 cycles after done.

Source files
------------

// File: rtl/test_sequencer_pkg.sv
// Shared definitions for the board self-test sequencer: FSM state encoding and loop-gap length.
package test_sequencer_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SELECT,
    INIT,
    WAIT_START,
    WAIT_END,
    NEXT,
    FINISH,
    LOOP_GAP
  } seq_state_e;

  localparam int unsigned LOOP_GAP_CYCLES = 32'd65536;

endpackage

// File: rtl/seq_timer.sv
// Clear/enable saturating phase timer with a combinational terminal-count compare.
module seq_timer #(
  parameter int unsigned W = 24
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr_i,
  input  logic         en_i,
  input  logic [W-1:0] term_i,
  output logic         hit_c_o
);

  logic [W-1:0] cnt_q, cnt_d;

  // Clear wins over count; the counter parks at all-ones instead of wrapping.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign hit_c_o = (cnt_q == term_i);

endmodule

// File: rtl/test_sequencer.sv
// Runs the selected board self-test engines one at a time and collects pass/fail/timeout masks.
// Define TEST_SEQUENCER_LOOP_EN to relaunch the sequence forever with sticky failure masks.
module test_sequencer
  import test_sequencer_pkg::*;
#(
  parameter int unsigned NUM_TESTS     = 4,
  parameter int unsigned INIT_CYCLES   = 16,
  parameter int unsigned START_TIMEOUT = 1024,
  parameter int unsigned RUN_TIMEOUT   = 4194304,
  parameter int unsigned TMR_W         = 24,
  localparam int unsigned CUR_W        = (NUM_TESTS > 1) ? $clog2(NUM_TESTS) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start_i,
  input  logic [NUM_TESTS-1:0] run_mask_i,
  input  logic [NUM_TESTS-1:0] test_progress_i,
  input  logic [NUM_TESTS-1:0] test_result_i,
  output logic [NUM_TESTS-1:0] test_init_o,
  output logic                 busy_o,
  output logic                 done_o,
  output logic [CUR_W-1:0]     cur_test_o,
  output logic [NUM_TESTS-1:0] pass_mask_o,
  output logic [NUM_TESTS-1:0] fail_mask_o,
  output logic [NUM_TESTS-1:0] timeout_mask_o,
  output logic                 led_ok_o
);

  seq_state_e           state_q, state_d;
  logic [NUM_TESTS-1:0] pending_q, pending_d;
  logic [NUM_TESTS-1:0] run_q, run_d;
  logic [CUR_W-1:0]     cur_q, cur_d;
  logic [NUM_TESTS-1:0] pass_q, pass_d;
  logic [NUM_TESTS-1:0] fail_q, fail_d;
  logic [NUM_TESTS-1:0] tmo_q, tmo_d;
  logic [NUM_TESTS-1:0] init_q, init_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 led_q, led_d;

  logic                 tmr_clr, tmr_en, tmr_hit;
  logic [TMR_W-1:0]     tmr_term;
  logic [CUR_W-1:0]     sel_idx;

  seq_timer #(.W(TMR_W)) u_timer (
    .clk     (clk),
    .rst     (rst),
    .clr_i   (tmr_clr),
    .en_i    (tmr_en),
    .term_i  (tmr_term),
    .hit_c_o (tmr_hit)
  );

  // Next-state, mask updates and registered-output values.
  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    run_d     = run_q;
    cur_d     = cur_q;
    pass_d    = pass_q;
    fail_d    = fail_q;
    tmo_d     = tmo_q;
    led_d     = led_q;
    tmr_en    = 1'b0;
    tmr_term  = '0;
    init_d    = '0;

    // Lowest pending index wins, so engine 0 always runs first.
    sel_idx = '0;
    for (int i = int'(NUM_TESTS) - 1; i >= 0; i--) begin
      if (pending_q[i]) sel_idx = CUR_W'(i);
    end

    case (state_q)
      IDLE: begin
        if (start_i) begin
          pending_d = run_mask_i;
          run_d     = run_mask_i;
          pass_d    = '0;
          fail_d    = '0;
          tmo_d     = '0;
          state_d   = SELECT;
        end
      end
      SELECT: begin
        if (pending_q == '0) begin
          state_d = FINISH;
        end else begin
          cur_d   = sel_idx;
          state_d = INIT;
        end
      end
      INIT: begin
        tmr_en   = 1'b1;
        tmr_term = TMR_W'(INIT_CYCLES - 1);
        if (tmr_hit) state_d = WAIT_START;
      end
      WAIT_START: begin
        tmr_en   = 1'b1;
        tmr_term = TMR_W'(START_TIMEOUT - 1);
        if (test_progress_i[cur_q]) begin
          state_d = WAIT_END;
        end else if (tmr_hit) begin
          fail_d[cur_q] = 1'b1;
          tmo_d[cur_q]  = 1'b1;
          state_d       = NEXT;
        end
      end
      WAIT_END: begin
        tmr_en   = 1'b1;
        tmr_term = TMR_W'(RUN_TIMEOUT - 1);
        if (!test_progress_i[cur_q]) begin
          if (test_result_i[cur_q]) pass_d[cur_q] = 1'b1;
          else                      fail_d[cur_q] = 1'b1;
          state_d = NEXT;
        end else if (tmr_hit) begin
          fail_d[cur_q] = 1'b1;
          tmo_d[cur_q]  = 1'b1;
          state_d       = NEXT;
        end
      end
      NEXT: begin
        pending_d[cur_q] = 1'b0;
        state_d          = SELECT;
      end
      FINISH: begin
`ifdef TEST_SEQUENCER_LOOP_EN
        state_d = LOOP_GAP;
`else
        state_d = IDLE;
`endif
      end
      LOOP_GAP: begin
        tmr_term = TMR_W'(LOOP_GAP_CYCLES - 1);
`ifdef TEST_SEQUENCER_LOOP_EN
        // Failures stay sticky across loops; passes are recomputed each loop.
        tmr_en = 1'b1;
        if (tmr_hit) begin
          pending_d = run_q;
          pass_d    = '0;
          state_d   = SELECT;
        end
`else
        state_d = IDLE;
`endif
      end
      default: state_d = IDLE;
    endcase

    tmr_clr = (state_d != state_q);
    done_d  = (state_d == FINISH);
`ifdef TEST_SEQUENCER_LOOP_EN
    busy_d  = (state_d != IDLE);
`else
    busy_d  = (state_d != IDLE) && (state_d != FINISH);
`endif
    if (state_d == INIT) init_d[cur_d] = 1'b1;
    if (state_d == FINISH) led_d = (fail_d == '0) && (run_d != '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      pending_q <= '0;
      run_q     <= '0;
      cur_q     <= '0;
      pass_q    <= '0;
      fail_q    <= '0;
      tmo_q     <= '0;
      init_q    <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      led_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      run_q     <= run_d;
      cur_q     <= cur_d;
      pass_q    <= pass_d;
      fail_q    <= fail_d;
      tmo_q     <= tmo_d;
      init_q    <= init_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      led_q     <= led_d;
    end
  end

  assign test_init_o    = init_q;
  assign busy_o         = busy_q;
  assign done_o         = done_q;
  assign cur_test_o     = cur_q;
  assign pass_mask_o    = pass_q;
  assign fail_mask_o    = fail_q;
  assign timeout_mask_o = tmo_q;
  assign led_ok_o       = led_q;

endmodule

// File: tb/tb_test_sequencer.sv
// Scoreboard bench for test_sequencer: engine models respond to init pulses, a cycle-level
// reference model predicts masks and done latency, and a monitor checks each done/init event.
module tb_test_sequencer;

  localparam int unsigned N       = 4;
  localparam int unsigned INIT_C  = 16;
  localparam int unsigned START_TO = 1024;
  localparam int unsigned RUN_TO  = 64;
  localparam int          GAP     = 65536;
`ifdef TEST_SEQUENCER_LOOP_EN
  localparam int          LOOP    = 1;
`else
  localparam int          LOOP    = 0;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start_i = 1'b0;
  logic [N-1:0] run_mask_i = '0;
  logic [N-1:0] test_progress_i = '0;
  logic [N-1:0] test_result_i = '0;
  logic [N-1:0] test_init_o, pass_mask_o, fail_mask_o, timeout_mask_o;
  logic         busy_o, done_o, led_ok_o;
  logic [1:0]   cur_test_o;

  test_sequencer #(
    .NUM_TESTS(N), .INIT_CYCLES(INIT_C), .START_TIMEOUT(START_TO),
    .RUN_TIMEOUT(RUN_TO), .TMR_W(24)
  ) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .run_mask_i(run_mask_i),
    .test_progress_i(test_progress_i), .test_result_i(test_result_i),
    .test_init_o(test_init_o), .busy_o(busy_o), .done_o(done_o),
    .cur_test_o(cur_test_o), .pass_mask_o(pass_mask_o), .fail_mask_o(fail_mask_o),
    .timeout_mask_o(timeout_mask_o), .led_ok_o(led_ok_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [N-1:0] run, pass, fail, tmo;
    logic         led;
    int           lat;
    int           start_cyc;
  } exp_t;

  exp_t exp_q[$];
  int   order_q[$];
  int   checks = 0;
  int   errors = 0;
  int   last_done_cyc = 0;

  // Engine behaviour: progress rises e_d cycles after init falls, stays high e_h cycles.
  int   e_d[N];
  int   e_h[N];
  bit   e_never[N];
  bit   eng_clear = 1'b0;
  int   ph[N];
  int   cnt[N];
  logic [N-1:0] prev_init = '0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    #2;
    for (int i = 0; i < N; i++) begin
      if (eng_clear) begin
        ph[i] = 0; cnt[i] = 0; test_progress_i[i] = 1'b0;
      end else begin
        if (prev_init[i] && !test_init_o[i]) begin
          ph[i] = 1; cnt[i] = 0;
        end else if (ph[i] != 0) begin
          cnt[i]++;
        end
        if (ph[i] == 1 && !e_never[i] && cnt[i] == e_d[i]) begin
          test_progress_i[i] = 1'b1; ph[i] = 2; cnt[i] = 0;
        end else if (ph[i] == 2 && cnt[i] == e_h[i]) begin
          test_progress_i[i] = 1'b0; ph[i] = 0;
        end
      end
    end
    prev_init = test_init_o;
  end

  // Reference model: per selected engine, cycles from its SELECT to the next SELECT.
  function automatic exp_t model(input logic [N-1:0] run);
    exp_t e;
    int   sum = 0;
    e.run = run; e.pass = '0; e.fail = '0; e.tmo = '0; e.start_cyc = 0;
    for (int i = 0; i < N; i++) begin
      if (run[i]) begin
        // Fixed overhead per test: select, init pulse, next (+ detect cycle when it starts).
        if (e_never[i] || e_d[i] >= int'(START_TO)) begin
          e.fail[i] = 1'b1; e.tmo[i] = 1'b1;
          sum += 2 + int'(INIT_C) + int'(START_TO);
        end else if (e_h[i] > int'(RUN_TO)) begin
          e.fail[i] = 1'b1; e.tmo[i] = 1'b1;
          sum += 3 + int'(INIT_C) + e_d[i] + int'(RUN_TO);
        end else begin
          if (test_result_i[i]) e.pass[i] = 1'b1;
          else                  e.fail[i] = 1'b1;
          sum += 3 + int'(INIT_C) + e_d[i] + e_h[i];
        end
      end
    end
    e.led = (run != '0) && (e.fail == '0);
    e.lat = 2 + sum;
    return e;
  endfunction

  logic [N-1:0] mon_prev = '0;
  int           init_len = 0;

  always @(negedge clk) begin
    exp_t e;
    int   idx;
    if (rst) begin
      mon_prev = '0;
      init_len = 0;
    end else begin
      if (test_init_o != '0 && mon_prev == '0) begin
        chk("init_onehot", int'($onehot(test_init_o)), 1);
        chk("busy_during_run", int'(busy_o), 1);
        if (order_q.size() == 0) begin
          chk("init_unexpected", int'(test_init_o), 0);
        end else begin
          idx = order_q.pop_front();
          chk("init_index", int'(test_init_o), 1 << idx);
          chk("cur_test", int'(cur_test_o), idx);
        end
        init_len = 1;
      end else if (test_init_o != '0) begin
        init_len++;
      end else if (mon_prev != '0) begin
        chk("init_len", init_len, int'(INIT_C));
      end
      if (done_o) begin
        if (exp_q.size() == 0) begin
          chk("done_unexpected", int'(done_o), 0);
        end else begin
          e = exp_q.pop_front();
          chk("pass_mask", int'(pass_mask_o), int'(e.pass));
          chk("fail_mask", int'(fail_mask_o), int'(e.fail));
          chk("timeout_mask", int'(timeout_mask_o), int'(e.tmo));
          chk("led_ok", int'(led_ok_o), int'(e.led));
          chk("done_latency", cyc - e.start_cyc, e.lat);
          chk("busy_at_done", int'(busy_o), LOOP);
          chk("pass_and_fail", int'(pass_mask_o & fail_mask_o), int'(e.pass & e.fail));
        end
        last_done_cyc = cyc;
      end
      mon_prev = test_init_o;
    end
  end

  task automatic cfg_all(input int d, input int h);
    for (int i = 0; i < N; i++) begin
      e_d[i] = d; e_h[i] = h; e_never[i] = 1'b0;
    end
  endtask

  task automatic engines_idle();
    eng_clear = 1'b1;
    repeat (2) @(posedge clk);
    #1 eng_clear = 1'b0;
  endtask

  task automatic issue_start(input logic [N-1:0] run, output exp_t e);
    e = model(run);
    @(posedge clk); #1;
    run_mask_i = run;
    start_i    = 1'b1;
    e.start_cyc = cyc;
    exp_q.push_back(e);
    for (int i = 0; i < N; i++) if (run[i]) order_q.push_back(i);
    @(posedge clk); #1;
    start_i    = 1'b0;
    run_mask_i = N'($urandom);
  endtask

  task automatic run_seq(input logic [N-1:0] run, input bit extra_start);
    exp_t e;
    int   n = 0;
    issue_start(run, e);
    if (extra_start) begin
      while (test_progress_i == '0 && n < 2000) begin @(posedge clk); n++; end
      chk("progress_seen", int'(test_progress_i != '0), 1);
      repeat (10) @(posedge clk);
      #1 start_i = 1'b1; run_mask_i = '1;
      @(posedge clk); #1 start_i = 1'b0;
    end
    n = 0;
    while (exp_q.size() != 0 && n < e.lat + 40) begin @(posedge clk); n++; end
    if (exp_q.size() != 0) begin
      chk("done_timeout", exp_q.size(), 0);
      exp_q.delete();
    end
    chk("all_inits_seen", order_q.size(), 0);
    order_q.delete();
    #1;
    engines_idle();
    repeat (3) @(posedge clk);
    #1;
    chk("pass_hold", int'(pass_mask_o), int'(e.pass));
    chk("fail_hold", int'(fail_mask_o), int'(e.fail));
    chk("led_hold", int'(led_ok_o), int'(e.led));
  endtask

  task automatic reset_checks(input string tag);
    chk({tag, "_init"}, int'(test_init_o), 0);
    chk({tag, "_busy"}, int'(busy_o), 0);
    chk({tag, "_done"}, int'(done_o), 0);
    chk({tag, "_cur"}, int'(cur_test_o), 0);
    chk({tag, "_pass"}, int'(pass_mask_o), 0);
    chk({tag, "_fail"}, int'(fail_mask_o), 0);
    chk({tag, "_tmo"}, int'(timeout_mask_o), 0);
    chk({tag, "_led"}, int'(led_ok_o), 0);
  endtask

  initial begin
    exp_t e;
    int   n;
    cfg_all(3, 40);
    repeat (3) @(posedge clk);
    #1;
    reset_checks("reset");
    rst = 1'b0;
`ifndef TEST_SEQUENCER_LOOP_EN
    test_result_i = 4'b1111;
    run_seq(4'b0101, 1'b0);
    e_never[1] = 1'b1;
    run_seq(4'b0010, 1'b0);
    e_never[1] = 1'b0;
    e_h[3] = 1000;
    run_seq(4'b1000, 1'b0);
    cfg_all(3, 40);
    run_seq(4'b0000, 1'b0);
    // Timeout boundaries: h=64 passes, h=65 hangs, d=0 already-high, d=1023 last chance.
    e_h[0] = 64; e_h[1] = 65; e_d[2] = 0; e_d[3] = 1023;
    test_result_i = 4'b1011;
    run_seq(4'b1111, 1'b0);
    cfg_all(1024, 10);
    run_seq(4'b0001, 1'b0);
    cfg_all(2, 50);
    test_result_i = 4'b1111;
    run_seq(4'b0001, 1'b1);
    issue_start(4'b0011, e);
    n = 0;
    while (test_init_o == '0 && n < 50) begin @(posedge clk); n++; end
    chk("init_before_rst", int'(test_init_o), 1);
    repeat (5) @(posedge clk);
    @(negedge clk); #2;
    rst = 1'b1;
    #1;
    reset_checks("midrst");
    exp_q.delete();
    order_q.delete();
    engines_idle();
    #1 rst = 1'b0;
    test_result_i = 4'b0100;
    run_seq(4'b0110, 1'b0);
    repeat (12) begin
      for (int i = 0; i < N; i++) begin
        e_never[i] = ($urandom_range(0, 7) == 0);
        e_d[i]     = int'($urandom_range(0, 12));
        e_h[i]     = int'($urandom_range(1, 70));
      end
      test_result_i = N'($urandom);
      run_seq(N'($urandom), 1'b0);
    end
`else
    test_result_i = 4'b1111;
    e_never[0] = 1'b1;
    run_seq(4'b0001, 1'b0);
    e_never[0] = 1'b0;
    e = model(4'b0001);
    e.fail = e.fail | 4'b0001;
    e.tmo  = e.tmo | 4'b0001;
    e.led  = 1'b0;
    e.start_cyc = last_done_cyc + GAP;
    exp_q.push_back(e);
    order_q.push_back(0);
    repeat (100) @(posedge clk);
    #1 start_i = 1'b1; run_mask_i = 4'b1110;
    @(posedge clk); #1 start_i = 1'b0;
    chk("loop_gap_busy", int'(busy_o), 1);
    chk("loop_gap_init", int'(test_init_o), 0);
    n = 0;
    while (exp_q.size() != 0 && n < GAP + e.lat + 100) begin @(posedge clk); n++; end
    chk("loop_relaunch_done", exp_q.size(), 0);
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired at t=%0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
